// File: rtl/ad9866_slow_adc_if.sv
// ---------------------------------------------------------------------------
// ad9866_slow_adc_if
// Bundles the ADC78H90 serial pins, the scan enable and the result outputs of
// the slow housekeeping ADC scanner.
//   master modport (scanner): drives nADCCS/ADCCLK/ADCMOSI, res_*, ch_data,
//                             fsm_state; reads enable and ADCMISO.
//   slave modport (user/ADC): the mirror image.
// Valid/ready note: results carry no back-pressure; res_valid is a one-cycle
// strobe and res_ch/res_data stay stable until the next strobe.
// ---------------------------------------------------------------------------
interface ad9866_slow_adc_if;
    logic        enable;
    logic        nADCCS;
    logic        ADCCLK;
    logic        ADCMOSI;
    logic        ADCMISO;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic [95:0] ch_data;
    logic [1:0]  fsm_state;

    modport master (
        input  enable, ADCMISO,
        output nADCCS, ADCCLK, ADCMOSI, res_valid, res_ch, res_data, ch_data,
               fsm_state
    );

    modport slave (
        output enable, ADCMISO,
        input  nADCCS, ADCCLK, ADCMOSI, res_valid, res_ch, res_data, ch_data,
               fsm_state
    );
endinterface

// File: rtl/ad9866_slow_adc.sv
// ---------------------------------------------------------------------------
// ad9866_slow_adc
// Round-robin scanner for an ADC78H90 on an SPI-like link. Each frame shifts
// out a 16-bit control word (next channel address in bits 13:11) while
// shifting in the conversion of the address sent in the previous frame.
//   IF_clk : block clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   bus    : ad9866_slow_adc_if.master (pins, enable, results, fsm_state)
// Parameters: HALF_DIV (IF_clk cycles per ADCCLK half period), NUM_CH
// (channels scanned), PERIOD (IF_clk cycles between frame starts).
// ---------------------------------------------------------------------------
module ad9866_slow_adc #(
    parameter int HALF_DIV = 4,
    parameter int NUM_CH   = 4,
    parameter int PERIOD   = 1024
) (
    input  logic               IF_clk,
    input  logic               rst_n,
    ad9866_slow_adc_if.master  bus
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_SHIFT = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;

    localparam logic [7:0]  H_CNT   = 8'(HALF_DIV);
    localparam logic [15:0] PER_CNT = 16'(PERIOD);
    localparam logic [2:0]  LAST_CH = 3'(NUM_CH - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] pcnt_q, pcnt_d;      // cycles since last frame start, saturating
    logic        first_q, first_d;    // no frame started since reset
    logic [7:0]  hdiv_q, hdiv_d;      // position inside the current half period
    logic [5:0]  edge_q, edge_d;      // index of the next half-period boundary
    logic [15:0] word_q, word_d;      // control word, shifted out MSB first
    logic [11:0] shift_q, shift_d;    // only the low 12 received bits are kept
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        ncs_q, ncs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        rv_q, rv_d;
    logic [2:0]  res_ch_q, res_ch_d;
    logic [11:0] res_data_q, res_data_d;
    logic [95:0] ch_data_q, ch_data_d;

    logic [2:0]  next_ch;
    logic        start_ok;
    logic        tick;
    logic        launch;

    assign next_ch  = (cur_ch_q == LAST_CH) ? 3'd0 : cur_ch_q + 3'd1;
    assign start_ok = bus.enable && (first_q || (pcnt_q == PER_CNT));
    assign tick     = (hdiv_q == H_CNT);

    always_comb begin
        state_d    = state_q;
        pcnt_d     = (pcnt_q == PER_CNT) ? pcnt_q : pcnt_q + 16'd1;
        first_d    = first_q;
        hdiv_d     = hdiv_q;
        edge_d     = edge_q;
        word_d     = word_q;
        shift_d    = shift_q;
        cur_ch_d   = cur_ch_q;
        ncs_d      = ncs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rv_d       = 1'b0;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        ch_data_d  = ch_data_q;
        launch     = 1'b0;

        case (state_q)
            S_IDLE: begin
                launch = start_ok;
            end
            S_SHIFT: begin
                if (tick) begin
                    hdiv_d = 8'd1;
                    edge_d = edge_q + 6'd1;
                    if (edge_q == 6'd33) begin
                        // Frame end: publish what was clocked in during this frame.
                        // It belongs to cur_ch, the address sent one frame earlier.
                        state_d    = S_DONE;
                        ncs_d      = 1'b1;
                        sclk_d     = 1'b1;
                        mosi_d     = 1'b0;
                        rv_d       = 1'b1;
                        res_ch_d   = cur_ch_q;
                        res_data_d = shift_q;
                        for (int i = 0; i < 8; i++) begin
                            if (cur_ch_q == 3'(i)) begin
                                ch_data_d[12*i +: 12] = shift_q;
                            end
                        end
                        cur_ch_d   = next_ch;
                    end else if (edge_q[0]) begin
                        sclk_d = 1'b0;
                        mosi_d = word_q[15];
                        word_d = {word_q[14:0], 1'b0};
                    end else begin
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[10:0], bus.ADCMISO};
                    end
                end else begin
                    hdiv_d = hdiv_q + 8'd1;
                end
            end
            S_DONE: begin
                if (tick) begin
                    hdiv_d = 8'd1;
                    edge_d = edge_q + 6'd1;
                    // After 2H cycles of CS high the IDLE decision is taken in
                    // the same cycle, so back-to-back frames are 35H apart.
                    if (edge_q == 6'd35) begin
                        state_d = S_IDLE;
                        launch  = start_ok;
                    end
                end else begin
                    hdiv_d = hdiv_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            state_d = S_SHIFT;
            ncs_d   = 1'b0;
            sclk_d  = 1'b1;
            mosi_d  = 1'b0;
            pcnt_d  = 16'd1;
            first_d = 1'b0;
            hdiv_d  = 8'd1;
            edge_d  = 6'd1;
            word_d  = {2'b00, next_ch, 11'd0};
            shift_d = 12'd0;
        end
    end

    always_ff @(posedge IF_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pcnt_q     <= 16'd0;
            first_q    <= 1'b1;
            hdiv_q     <= 8'd0;
            edge_q     <= 6'd0;
            word_q     <= 16'd0;
            shift_q    <= 12'd0;
            cur_ch_q   <= 3'd0;
            ncs_q      <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rv_q       <= 1'b0;
            res_ch_q   <= 3'd0;
            res_data_q <= 12'd0;
            ch_data_q  <= 96'd0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            first_q    <= first_d;
            hdiv_q     <= hdiv_d;
            edge_q     <= edge_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            cur_ch_q   <= cur_ch_d;
            ncs_q      <= ncs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rv_q       <= rv_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            ch_data_q  <= ch_data_d;
        end
    end

    assign bus.nADCCS    = ncs_q;
    assign bus.ADCCLK    = sclk_q;
    assign bus.ADCMOSI   = mosi_q;
    assign bus.res_valid = rv_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_data  = res_data_q;
    assign bus.ch_data   = ch_data_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_ad9866_slow_adc.sv
// ---------------------------------------------------------------------------
// tb_ad9866_slow_adc
// Directed bench. dut_a: H=4, NUM_CH=4, PERIOD=1024. dut_b: H=4, NUM_CH=1,
// PERIOD=10. Each has a small ADC78H90 model that latches the address from
// DIN at the end of a frame and returns either a fixed word or 0x100+addr.
// ---------------------------------------------------------------------------
module tb_ad9866_slow_adc;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    ad9866_slow_adc_if bus_a();
    ad9866_slow_adc_if bus_b();

    ad9866_slow_adc #(.HALF_DIV(4), .NUM_CH(4), .PERIOD(1024)) dut_a (
        .IF_clk(clk), .rst_n(rst_a), .bus(bus_a.master)
    );
    ad9866_slow_adc #(.HALF_DIV(4), .NUM_CH(1), .PERIOD(10)) dut_b (
        .IF_clk(clk), .rst_n(rst_b), .bus(bus_b.master)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- ADC model A ----------------
    logic [4:0]  bc_a = 5'd0;
    logic [15:0] rx_a = 16'd0;
    logic [2:0]  addr_a = 3'd0;
    logic        fixed_mode = 1'b1;
    logic [15:0] tx_a;
    logic [15:0] din_a_q[$];
    assign tx_a = fixed_mode ? 16'h0ABC : (16'h0100 | {13'd0, addr_a});
    assign bus_a.ADCMISO = (bc_a < 5'd16) ? tx_a[4'd15 - bc_a[3:0]] : 1'b0;
    always @(posedge bus_a.ADCCLK or posedge bus_a.nADCCS or negedge rst_a) begin
        if (!rst_a) begin
            addr_a = 3'd0;
            bc_a   = 5'd0;
        end else if (bus_a.nADCCS) begin
            if (bc_a != 5'd0) begin
                din_a_q.push_back(rx_a);
                addr_a = rx_a[13:11];
            end
            bc_a = 5'd0;
        end else begin
            rx_a = {rx_a[14:0], bus_a.ADCMOSI};
            bc_a = bc_a + 5'd1;
        end
    end

    // ---------------- ADC model B ----------------
    logic [4:0]  bc_b = 5'd0;
    logic [15:0] rx_b = 16'd0;
    logic [2:0]  addr_b = 3'd0;
    logic [15:0] tx_b;
    logic [15:0] din_b_q[$];
    assign tx_b = 16'h0100 | {13'd0, addr_b};
    assign bus_b.ADCMISO = (bc_b < 5'd16) ? tx_b[4'd15 - bc_b[3:0]] : 1'b0;
    always @(posedge bus_b.ADCCLK or posedge bus_b.nADCCS or negedge rst_b) begin
        if (!rst_b) begin
            addr_b = 3'd0;
            bc_b   = 5'd0;
        end else if (bus_b.nADCCS) begin
            if (bc_b != 5'd0) begin
                din_b_q.push_back(rx_b);
                addr_b = rx_b[13:11];
            end
            bc_b = 5'd0;
        end else begin
            rx_b = {rx_b[14:0], bus_b.ADCMOSI};
            bc_b = bc_b + 5'd1;
        end
    end

    // ---------------- result / edge monitors ----------------
    logic [14:0] res_a_q[$];
    logic [14:0] res_b_q[$];
    int          falls_a[$];
    int          falls_b[$];
    int          rv_a = 0;
    logic        prev_a = 1'b1;
    logic        prev_b = 1'b1;
    always @(negedge clk) begin
        if (bus_a.res_valid) begin
            rv_a++;
            res_a_q.push_back({bus_a.res_ch, bus_a.res_data});
        end
        if (bus_b.res_valid) res_b_q.push_back({bus_b.res_ch, bus_b.res_data});
        if (prev_a && !bus_a.nADCCS) falls_a.push_back(cyc);
        if (prev_b && !bus_b.nADCCS) falls_b.push_back(cyc);
        prev_a = bus_a.nADCCS;
        prev_b = bus_b.nADCCS;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [14:0] exp_q[$];
    initial begin
        int n, low_cyc, sclk_low, base_rv, base_res, base_din, base_fall, t0c, rvr;
        int exp_ch[6];
        int exp_addr[6];
        exp_ch   = '{0, 1, 2, 3, 0, 1};
        exp_addr = '{1, 2, 3, 0, 1, 2};
        bus_a.enable = 1'b0;
        bus_b.enable = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ncs",   96'(bus_a.nADCCS),    96'(1));
        check("rst_sclk",  96'(bus_a.ADCCLK),    96'(1));
        check("rst_mosi",  96'(bus_a.ADCMOSI),   96'(0));
        check("rst_rv",    96'(bus_a.res_valid), 96'(0));
        check("rst_ch",    96'(bus_a.res_ch),    96'(0));
        check("rst_data",  96'(bus_a.res_data),  96'(0));
        check("rst_chd",   bus_a.ch_data,        96'(0));
        check("rst_state", 96'(bus_a.fsm_state), 96'(0));

        // single frame with fixed ADC word 0x0ABC
        rst_a = 1'b1;
        @(negedge clk);
        bus_a.enable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus_a.nADCCS && n < 20);
        check("first_start_lat", 96'(n), 96'(1));
        base_rv = rv_a;
        low_cyc = 0;
        sclk_low = 0;
        while (!bus_a.nADCCS && low_cyc < 300) begin
            if (!bus_a.ADCCLK) sclk_low++;
            low_cyc++;
            @(negedge clk);
        end
        check("cs_low_cycles",   96'(low_cyc),        96'(132));
        check("sclk_low_cycles", 96'(sclk_low),       96'(64));
        check("single_rv",       96'(bus_a.res_valid), 96'(1));
        check("single_ch",       96'(bus_a.res_ch),    96'(0));
        check("single_data",     96'(bus_a.res_data),  96'(12'hABC));
        check("single_chd0",     96'(bus_a.ch_data[11:0]), 96'(12'hABC));
        check("single_din", 96'((din_a_q.size() > 0) ? din_a_q[$] : 16'hFFFF), 96'(16'h0800));
        @(negedge clk);
        #1;
        check("single_rv_pulse", 96'(bus_a.res_valid), 96'(0));
        check("single_rv_count", 96'(rv_a - base_rv),  96'(1));
        check("hold_data",       96'(bus_a.res_data),  96'(12'hABC));
        bus_a.enable = 1'b0;

        // channel scan from a fresh reset
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        fixed_mode = 1'b0;
        #1;
        base_res  = res_a_q.size();
        base_din  = din_a_q.size();
        base_fall = falls_a.size();
        bus_a.enable = 1'b1;
        n = 0;
        while (res_a_q.size() < base_res + 6 && n < 6500) begin @(negedge clk); #1; n++; end
        check("scan_done", 96'(res_a_q.size() >= base_res + 6), 96'(1));
        for (int i = 0; i < 6; i++) exp_q.push_back({3'(exp_ch[i]), 12'(12'h100 + exp_ch[i])});
        for (int i = 0; i < 6; i++) begin
            logic [14:0] e;
            e = exp_q.pop_front();
            check($sformatf("scan_res%0d", i),
                  96'((res_a_q.size() > base_res + i) ? res_a_q[base_res + i] : 15'h7FFF), 96'(e));
            check($sformatf("scan_din%0d", i),
                  96'((din_a_q.size() > base_din + i) ? din_a_q[base_din + i] : 16'hFFFF),
                  96'({2'b00, 3'(exp_addr[i]), 11'd0}));
        end
        for (int i = 1; i < 6; i++) begin
            check($sformatf("period_gap%0d", i),
                  96'((falls_a.size() > base_fall + i) ?
                      falls_a[base_fall + i] - falls_a[base_fall + i - 1] : -1), 96'(1024));
        end
        check("scan_chdata", bus_a.ch_data, 96'h000000000000_103_102_101_100);

        // enable dropped mid-frame: frame still completes
        base_fall = falls_a.size();
        n = 0;
        while (falls_a.size() == base_fall && n < 1200) begin @(negedge clk); #1; n++; end
        check("drop_frame_start", 96'(falls_a.size()), 96'(base_fall + 1));
        t0c = (falls_a.size() > 0) ? falls_a[$] : 0;
        repeat (50) @(negedge clk);
        bus_a.enable = 1'b0;
        base_rv = rv_a;
        n = 0;
        while (rv_a == base_rv && n < 200) begin @(negedge clk); #1; n++; end
        check("drop_rv_time", 96'(cyc - t0c), 96'(132));
        repeat (2000) @(negedge clk);
        #1;
        check("drop_no_restart", 96'(falls_a.size()), 96'(base_fall + 1));

        // re-enable after more than PERIOD idle cycles: immediate start
        bus_a.enable = 1'b1;
        @(negedge clk);
        check("reenable_start", 96'(bus_a.nADCCS), 96'(0));

        // reset in the middle of that frame
        repeat (69) @(negedge clk);
        check("mid_sclk_low", 96'(bus_a.ADCCLK), 96'(0));
        rvr = rv_a;
        rst_a = 1'b0;
        #1;
        check("midrst_ncs",   96'(bus_a.nADCCS),    96'(1));
        check("midrst_sclk",  96'(bus_a.ADCCLK),    96'(1));
        check("midrst_state", 96'(bus_a.fsm_state), 96'(0));
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_rv",  96'(rv_a - rvr),     96'(0));
        check("midrst_chdata", bus_a.ch_data,       96'(0));
        base_res = res_a_q.size();
        rst_a = 1'b1;
        n = 0;
        while (res_a_q.size() == base_res && n < 300) begin @(negedge clk); #1; n++; end
        check("postrst_res",
              96'((res_a_q.size() > base_res) ? res_a_q[base_res] : 15'h7FFF),
              96'({3'd0, 12'h100}));
        bus_a.enable = 1'b0;

        // single-channel unit, back-to-back frames
        @(negedge clk);
        rst_b = 1'b1;
        bus_b.enable = 1'b1;
        n = 0;
        while (res_b_q.size() < 3 && n < 600) begin @(negedge clk); #1; n++; end
        check("b_done", 96'(res_b_q.size() >= 3), 96'(1));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_res%0d", i),
                  96'((res_b_q.size() > i) ? res_b_q[i] : 15'h7FFF), 96'({3'd0, 12'h100}));
            check($sformatf("b_din%0d", i),
                  96'((din_b_q.size() > i) ? din_b_q[i] : 16'hFFFF), 96'(16'h0000));
        end
        for (int i = 1; i < 3; i++) begin
            check($sformatf("b_gap%0d", i),
                  96'((falls_b.size() > i) ? falls_b[i] - falls_b[i - 1] : -1), 96'(140));
        end
        bus_b.enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
